// File: rtl/memref_responder.sv
// Single-read/single-write memory responder with a RD_LATENCY-deep read pipeline.
// Optional write-forwarding on same-cycle same-address access: define MEMREF_RESP_FWD_EN.
module memref_responder #(
  parameter int WIDTH      = 32,
  parameter int SIZE       = 256,
  parameter int ADDR_W     = 8,
  parameter int RD_LATENCY = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              p0_addr_en,
  input  logic [ADDR_W-1:0] p0_addr_data,
  input  logic              p0_rd_en,
  output logic [WIDTH-1:0]  p0_rd_data,
  output logic              p0_rd_valid,
  input  logic              p1_addr_en,
  input  logic [ADDR_W-1:0] p1_addr_data,
  input  logic              p1_wr_en,
  input  logic [WIDTH-1:0]  p1_wr_data,
  output logic              err_oob,
  output logic              err_proto
);
  localparam int AW = (SIZE > 1) ? $clog2(SIZE) : 1;
  localparam logic [ADDR_W:0] SIZE_C = (ADDR_W+1)'(SIZE);

  logic [WIDTH-1:0] mem [SIZE];

  logic w_rd_acc, w_rd_inr, w_wr_acc, w_wr_inr;
  logic [WIDTH-1:0] w_rd_word;

  logic [RD_LATENCY-1:0]            r_vld;
  logic [RD_LATENCY-1:0]            r_inr;
  logic [RD_LATENCY-1:0][WIDTH-1:0] r_dat;
  logic r_err_oob, r_err_proto;

  assign w_rd_acc = p0_addr_en & p0_rd_en;
  assign w_wr_acc = p1_addr_en & p1_wr_en;
  assign w_rd_inr = ({1'b0, p0_addr_data} < SIZE_C);
  assign w_wr_inr = ({1'b0, p1_addr_data} < SIZE_C);

  always_comb begin
    w_rd_word = '0;
    if (w_rd_inr) w_rd_word = mem[p0_addr_data[AW-1:0]];
`ifdef MEMREF_RESP_FWD_EN
    if (w_rd_inr && w_wr_acc && w_wr_inr && (p1_addr_data == p0_addr_data))
      w_rd_word = p1_wr_data;
`endif
  end

  // Storage is deliberately left unreset.
  always_ff @(posedge clk) begin
    if (w_wr_acc && w_wr_inr) mem[p1_addr_data[AW-1:0]] <= p1_wr_data;
  end

  // Data/in-range fields only advance behind a valid bit, so the last stage
  // holds the most recent returned word between pulses.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_vld[0] <= 1'b0;
      r_inr[0] <= 1'b0;
      r_dat[0] <= '0;
    end else begin
      r_vld[0] <= w_rd_acc;
      if (w_rd_acc) begin
        r_inr[0] <= w_rd_inr;
        r_dat[0] <= w_rd_word;
      end
    end
  end

  for (genvar s = 1; s < RD_LATENCY; s++) begin : g_stage
    always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
        r_vld[s] <= 1'b0;
        r_inr[s] <= 1'b0;
        r_dat[s] <= '0;
      end else begin
        r_vld[s] <= r_vld[s-1];
        if (r_vld[s-1]) begin
          r_inr[s] <= r_inr[s-1];
          r_dat[s] <= r_dat[s-1];
        end
      end
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      r_err_oob   <= 1'b0;
      r_err_proto <= 1'b0;
    end else begin
      if ((w_rd_acc && !w_rd_inr) || (w_wr_acc && !w_wr_inr)) r_err_oob <= 1'b1;
      if ((p0_rd_en && !p0_addr_en) || (p1_wr_en && !p1_addr_en)) r_err_proto <= 1'b1;
    end
  end

  assign p0_rd_valid = r_vld[RD_LATENCY-1];
  assign p0_rd_data  = r_inr[RD_LATENCY-1] ? r_dat[RD_LATENCY-1] : '0;
  assign err_oob     = r_err_oob;
  assign err_proto   = r_err_proto;
endmodule

// File: tb/tb_memref_responder.sv
// Directed bench: two responders (RD_LATENCY 2 and 3, SIZE 64) share one stimulus stream.
module tb_memref_responder;
  logic        clk = 1'b0;
  logic        rst;
  logic        p0_addr_en, p0_rd_en, p1_addr_en, p1_wr_en;
  logic [7:0]  p0_addr_data, p1_addr_data;
  logic [31:0] p1_wr_data;
  logic [31:0] d2, d3;
  logic        v2, v3, oob2, oob3, pro2, pro3;
  int          n_chk = 0;
  int          n_fail = 0;

  always #5 clk = ~clk;

  memref_responder #(.WIDTH(32), .SIZE(64), .ADDR_W(8), .RD_LATENCY(2)) u_l2 (
    .clk(clk), .rst(rst),
    .p0_addr_en(p0_addr_en), .p0_addr_data(p0_addr_data), .p0_rd_en(p0_rd_en),
    .p0_rd_data(d2), .p0_rd_valid(v2),
    .p1_addr_en(p1_addr_en), .p1_addr_data(p1_addr_data), .p1_wr_en(p1_wr_en),
    .p1_wr_data(p1_wr_data), .err_oob(oob2), .err_proto(pro2));

  memref_responder #(.WIDTH(32), .SIZE(64), .ADDR_W(8), .RD_LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst),
    .p0_addr_en(p0_addr_en), .p0_addr_data(p0_addr_data), .p0_rd_en(p0_rd_en),
    .p0_rd_data(d3), .p0_rd_valid(v3),
    .p1_addr_en(p1_addr_en), .p1_addr_data(p1_addr_data), .p1_wr_en(p1_wr_en),
    .p1_wr_data(p1_wr_data), .err_oob(oob3), .err_proto(pro3));

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h want %h", tag, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic idle();
    p0_addr_en = 1'b0; p0_rd_en = 1'b0; p0_addr_data = '0;
    p1_addr_en = 1'b0; p1_wr_en = 1'b0; p1_addr_data = '0; p1_wr_data = '0;
  endtask

  task automatic do_write(input logic [7:0] a, input logic [31:0] d);
    p1_addr_en = 1'b1; p1_wr_en = 1'b1; p1_addr_data = a; p1_wr_data = d;
    tick();
    idle();
  endtask

  task automatic set_read(input logic [7:0] a);
    p0_addr_en = 1'b1; p0_rd_en = 1'b1; p0_addr_data = a;
  endtask

  // Called just after the accepting edge; c counts edges from that one.
  task automatic obs_read(input string tag, input logic [31:0] exp);
    for (int c = 1; c <= 4; c++) begin
      chk({tag, "_v2"}, 32'(v2), 32'(c == 2));
      chk({tag, "_v3"}, 32'(v3), 32'(c == 3));
      if (c >= 2) chk({tag, "_d2"}, d2, exp);
      if (c >= 3) chk({tag, "_d3"}, d3, exp);
      if (c < 4) tick();
    end
  endtask

  task automatic do_read(input string tag, input logic [7:0] a, input logic [31:0] exp);
    set_read(a);
    tick();
    idle();
    obs_read(tag, exp);
  endtask

  task automatic chk_zero_outs(input string tag);
    chk({tag, "_v2"}, 32'(v2), 32'd0);
    chk({tag, "_v3"}, 32'(v3), 32'd0);
    chk({tag, "_d2"}, d2, 32'd0);
    chk({tag, "_d3"}, d3, 32'd0);
    chk({tag, "_oob"}, 32'({oob2, oob3}), 32'd0);
    chk({tag, "_pro"}, 32'({pro2, pro3}), 32'd0);
  endtask

  initial begin
    idle();
    rst = 1'b0;
    tick(); tick();
    chk_zero_outs("rst");
    rst = 1'b1;

    // Latency
    do_write(8'd5, 32'hDEADBEEF);
    do_read("lat", 8'd5, 32'hDEADBEEF);

    // Back-to-back burst
    for (int i = 0; i < 4; i++) do_write(8'(i), 32'(i + 100));
    for (int t = 1; t <= 7; t++) begin
      if (t <= 4) set_read(8'(t - 1)); else idle();
      tick();
      chk("burst_v2", 32'(v2), 32'(t >= 2 && t <= 5));
      chk("burst_v3", 32'(v3), 32'(t >= 3 && t <= 6));
      if (t >= 2 && t <= 5) chk("burst_d2", d2, 32'(100 + t - 2));
      if (t >= 3 && t <= 6) chk("burst_d3", d3, 32'(100 + t - 3));
    end
    idle();
    tick();

    // Same-cycle read/write collision
    do_write(8'd7, 32'h11);
    set_read(8'd7);
    p1_addr_en = 1'b1; p1_wr_en = 1'b1; p1_addr_data = 8'd7; p1_wr_data = 32'h22;
    tick();
    idle();
`ifdef MEMREF_RESP_FWD_EN
    obs_read("coll", 32'h22);
`else
    obs_read("coll", 32'h11);
`endif
    do_read("coll_after", 8'd7, 32'h22);

    // Address enable without request is a no-op
    p0_addr_en = 1'b1; p0_addr_data = 8'd5;
    p1_addr_en = 1'b1; p1_addr_data = 8'd5; p1_wr_data = 32'h0BAD;
    tick();
    idle();
    tick();
    chk("noop_v", 32'({v2, v3}), 32'd0);
    chk("noop_err", 32'({oob2, oob3, pro2, pro3}), 32'd0);
    do_read("noop_mem", 8'd5, 32'hDEADBEEF);

    // Out of range
    do_write(8'd16, 32'h1616);
    do_write(8'd9, 32'h99);
    do_read("oob_rd", 8'd70, 32'd0);
    chk("oob_flag_rd", 32'({oob2, oob3}), 32'b11);
    do_write(8'd80, 32'hBAD0BAD0);
    do_read("oob_alias", 8'd16, 32'h1616);
    chk("oob_flag", 32'({oob2, oob3}), 32'b11);
    chk("oob_pro", 32'({pro2, pro3}), 32'd0);

    // Protocol violation
    p0_rd_en = 1'b1; p0_addr_data = 8'd5;
    tick();
    idle();
    for (int c = 1; c <= 4; c++) begin
      chk("pro_v", 32'({v2, v3}), 32'd0);
      tick();
    end
    chk("pro_flag", 32'({pro2, pro3}), 32'b11);
    for (int i = 0; i < 10; i++) do_write(8'(20 + i), 32'(i));
    chk("pro_sticky", 32'({pro2, pro3}), 32'b11);
    chk("oob_sticky", 32'({oob2, oob3}), 32'b11);

    // Reset with reads in flight
    set_read(8'd5);
    tick();
    idle();
    rst = 1'b0;
    #1;
    chk_zero_outs("rst_fl0");
    tick();
    chk_zero_outs("rst_fl1");
    tick();
    chk_zero_outs("rst_fl2");
    rst = 1'b1;
    do_read("post_rst", 8'd9, 32'h99);

    $display("TB_RESULT checks=%0d failures=%0d", n_chk, n_fail);
    $finish;
  end
endmodule
